// File: rtl/rally_referee_pkg.sv
// Shared referee constants: player ids, ball geometry, net line and FSM state codes.
// The ball controller uses the same player and geometry constants.
package rally_referee_pkg;

   localparam logic PLAYER1 = 1'b0;
   localparam logic PLAYER2 = 1'b1;

   localparam int BALL_SIZE = 64;
   localparam int NET_X_DEF = 512;

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      POINT     = 2'd1,
      HOLD      = 2'd2,
      GAME_OVER = 2'd3
   } ref_state_t;

   // Player whose half holds the ball centre; that player loses a ground point.
   function automatic logic ground_loser(input logic [11:0] posx, input int net_x);
      logic [12:0] centre;
      centre = {1'b0, posx} + 13'(BALL_SIZE / 2);
      return (int'(centre) >= net_x) ? PLAYER2 : PLAYER1;
   endfunction

endpackage

// File: rtl/rally_referee_touch_filter.sv
// Turns a raw player/ball collision level into a one-cycle touch pulse.
// A rising edge inside the ghost window after the previous counted touch is dropped.
module rally_referee_touch_filter #(
   parameter int GHOST_CYC = 16_250_000
) (
   input  logic clk,
   input  logic rst,
   input  logic col,
   output logic touch
);

   localparam int GW = (GHOST_CYC > 1) ? $clog2(GHOST_CYC) : 1;

   logic          col_q;
   logic [GW-1:0] ghost;
   logic          hit;

   assign hit = col & ~col_q & (ghost == '0);

   // col_q resets high so a level held across reset is not taken as an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= 1'b1;
         ghost <= '0;
         touch <= 1'b0;
      end else begin
         col_q <= col;
         touch <= hit;
         if (hit)
            ghost <= GW'(GHOST_CYC - 1);
         else if (ghost != '0)
            ghost <= ghost - 1'b1;
      end
   end

endmodule

// File: rtl/rally_referee.sv
// Rally referee: counts touches per possession, awards points, holds between rallies
// and stops the game at the winning score.
module rally_referee
   import rally_referee_pkg::*;
#(
   parameter int GHOST_CYC = 16_250_000,
   parameter int HOLD_CYC  = 170_000_000,
   parameter int WIN_SCORE = 15,
   parameter int NET_X     = NET_X_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pl1_col,
   input  logic        pl2_col,
   input  logic        gnd_col,
   input  logic [11:0] ball_posx,
   input  logic        new_game,
   output logic        last_touch,
   output logic        ovr_touch,
   output logic        point_strobe,
   output logic [3:0]  pl1_score,
   output logic [3:0]  pl2_score,
   output logic        game_over,
   output logic [1:0]  state,
   output logic [2:0]  touch_cnt
);

   localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

   ref_state_t        cur_state, nxt_state;
   logic              touch1, touch2;
   logic              gnd_q, gnd_rise, gnd_win;
   logic              ovr_flag, nxt_ovr;
   logic              nxt_last, award, winner, toucher;
   logic [2:0]        nxt_cnt, cnt_inc;
   logic [3:0]        nxt_p1, nxt_p2;
   logic [HOLD_W-1:0] hold_timer, nxt_timer;

   rally_referee_touch_filter #(.GHOST_CYC(GHOST_CYC)) u_pl1 (
      .clk(clk), .rst(rst), .col(pl1_col), .touch(touch1)
   );
   rally_referee_touch_filter #(.GHOST_CYC(GHOST_CYC)) u_pl2 (
      .clk(clk), .rst(rst), .col(pl2_col), .touch(touch2)
   );

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s < WIN) ? s + 4'd1 : s;
   endfunction

   // Ground edge is registered like the touches, so both reach the FSM in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnd_q    <= 1'b1;
         gnd_rise <= 1'b0;
         gnd_win  <= PLAYER1;
      end else begin
         gnd_q    <= gnd_col;
         gnd_rise <= gnd_col & ~gnd_q;
         gnd_win  <= ~ground_loser(ball_posx, NET_X);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_state  <= PLAY;
         last_touch <= PLAYER1;
         touch_cnt  <= 3'd0;
         pl1_score  <= 4'd0;
         pl2_score  <= 4'd0;
         hold_timer <= '0;
         ovr_flag   <= 1'b0;
      end else begin
         cur_state  <= nxt_state;
         last_touch <= nxt_last;
         touch_cnt  <= nxt_cnt;
         pl1_score  <= nxt_p1;
         pl2_score  <= nxt_p2;
         hold_timer <= nxt_timer;
         ovr_flag   <= nxt_ovr;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      nxt_last  = last_touch;
      nxt_cnt   = touch_cnt;
      nxt_p1    = pl1_score;
      nxt_p2    = pl2_score;
      nxt_timer = hold_timer;
      nxt_ovr   = ovr_flag;
      award     = 1'b0;
      winner    = PLAYER1;
      cnt_inc   = touch_cnt + 3'd1;
      // Simultaneous touches: only the player taking over possession counts.
      toucher   = (touch1 & touch2) ? ~last_touch : touch2;

      case (cur_state)
         PLAY: begin
            if (gnd_rise) begin
               award   = 1'b1;
               winner  = gnd_win;
               nxt_ovr = 1'b0;
            end else if (touch1 | touch2) begin
               if (toucher != last_touch) begin
                  nxt_last = toucher;
                  nxt_cnt  = 3'd1;
               end else if (cnt_inc == 3'd4) begin
                  award   = 1'b1;
                  winner  = ~toucher;
                  nxt_ovr = 1'b1;
               end else begin
                  nxt_cnt = cnt_inc;
               end
            end
         end
         // last_touch already holds the winner here.
         POINT: nxt_state = (((last_touch == PLAYER2) ? pl2_score : pl1_score) == WIN) ? GAME_OVER : HOLD;
         HOLD: begin
            if (hold_timer < HOLD_LAST)
               nxt_timer = hold_timer + 1'b1;
            if (hold_timer >= HOLD_LAST && !gnd_col)
               nxt_state = PLAY;
         end
         GAME_OVER: begin
            if (new_game) begin
               nxt_p1    = 4'd0;
               nxt_p2    = 4'd0;
               nxt_last  = PLAYER1;
               nxt_cnt   = 3'd0;
               nxt_state = PLAY;
            end
         end
         default: nxt_state = PLAY;
      endcase

      // Score lands on entry to POINT so the strobe and the new score coincide.
      if (award) begin
         nxt_state = POINT;
         nxt_last  = winner;
         nxt_cnt   = 3'd0;
         nxt_timer = '0;
         if (winner == PLAYER2)
            nxt_p2 = sat_inc(pl2_score);
         else
            nxt_p1 = sat_inc(pl1_score);
      end
   end

   assign point_strobe = (cur_state == POINT);
   assign ovr_touch    = (cur_state == POINT) & ovr_flag;
   assign game_over    = (cur_state == GAME_OVER);
   assign state        = cur_state;

endmodule

// File: tb/tb_rally_referee.sv
// Self-checking bench for rally_referee: directed rally scenarios followed by a random
// phase, all checked every cycle against a cycle-stamped event model of the rules.
module tb_rally_referee;
   import rally_referee_pkg::*;

   localparam int G   = 8;
   localparam int H   = 16;
   localparam int W   = 3;
   localparam int NET = 512;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pl1_col = 1'b0, pl2_col = 1'b0, gnd_col = 1'b0, new_game = 1'b0;
   logic [11:0] ball_posx = 12'd0;
   logic        last_touch, ovr_touch, point_strobe, game_over;
   logic [3:0]  pl1_score, pl2_score;
   logic [1:0]  state;
   logic [2:0]  touch_cnt;

   always #5 clk = ~clk;

   rally_referee #(.GHOST_CYC(G), .HOLD_CYC(H), .WIN_SCORE(W), .NET_X(NET)) dut (
      .clk(clk), .rst(rst), .pl1_col(pl1_col), .pl2_col(pl2_col), .gnd_col(gnd_col),
      .ball_posx(ball_posx), .new_game(new_game), .last_touch(last_touch),
      .ovr_touch(ovr_touch), .point_strobe(point_strobe), .pl1_score(pl1_score),
      .pl2_score(pl2_score), .game_over(game_over), .state(state), .touch_cnt(touch_cnt)
   );

   int compared = 0;
   int mismatched = 0;

   // Reference model: rule-level view with cycle stamps instead of counters.
   ref_state_t m_mode;
   int         m_s [2];
   bit         m_last, m_ovr;
   int         m_cnt, n, hold_edge;
   int         lastc [2];
   bit         pv [2];
   bit         gpv, pend_g, pend_gw;
   bit         pend_t [2];
   bit         saw_both, saw_ovr;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = PLAY; m_s[0] = 0; m_s[1] = 0; m_last = 1'b0; m_ovr = 1'b0; m_cnt = 0;
      n = 0; hold_edge = 0; gpv = 1'b1; pend_g = 1'b0; pend_gw = 1'b0;
      for (int p = 0; p < 2; p++) begin
         lastc[p] = -1000; pv[p] = 1'b1; pend_t[p] = 1'b0;
      end
   endtask

   task automatic award(input bit w, input bit by_touch);
      if (m_s[w] < W) m_s[w]++;
      m_last = w; m_cnt = 0; m_ovr = by_touch; m_mode = POINT;
   endtask

   task automatic model_edge();
      bit nt [2];
      bit col [2];
      int who;
      col[0] = pl1_col; col[1] = pl2_col;
      n++;
      case (m_mode)
         PLAY: begin
            if (pend_g) award(pend_gw, 1'b0);
            else begin
               who = -1;
               if (pend_t[0] && pend_t[1]) who = m_last ? 0 : 1;
               else if (pend_t[0]) who = 0;
               else if (pend_t[1]) who = 1;
               if (who >= 0) begin
                  if (who == int'(m_last)) begin
                     if (m_cnt == 3) award((who == 0), 1'b1);
                     else m_cnt++;
                  end else begin
                     m_last = (who == 1); m_cnt = 1;
                  end
               end
            end
         end
         POINT: begin
            if (m_s[m_last] >= W) m_mode = GAME_OVER;
            else begin m_mode = HOLD; hold_edge = n; end
         end
         HOLD: if (n - hold_edge >= H && !gnd_col) m_mode = PLAY;
         GAME_OVER: if (new_game) begin
            m_s[0] = 0; m_s[1] = 0; m_last = 1'b0; m_cnt = 0; m_mode = PLAY;
         end
         default: m_mode = PLAY;
      endcase
      for (int p = 0; p < 2; p++) begin
         nt[p] = 1'b0;
         if (col[p] && !pv[p] && (n - lastc[p] >= G)) begin
            nt[p] = 1'b1; lastc[p] = n;
         end
         pv[p] = col[p];
      end
      pend_t = nt;
      pend_g = gnd_col && !gpv;
      if (pend_g) pend_gw = (int'(ball_posx) + BALL_SIZE / 2 < NET);
      gpv = gnd_col;
   endtask

   task automatic check_all();
      chk("state", 8'(state), 8'(m_mode));
      chk("pl1_score", 8'(pl1_score), 8'(m_s[0]));
      chk("pl2_score", 8'(pl2_score), 8'(m_s[1]));
      chk("last_touch", 8'(last_touch), 8'(m_last));
      chk("touch_cnt", 8'(touch_cnt), 8'(m_cnt));
      chk("point_strobe", 8'(point_strobe), 8'(m_mode == POINT));
      chk("ovr_touch", 8'(ovr_touch), 8'(m_mode == POINT && m_ovr));
      chk("game_over", 8'(game_over), 8'(m_mode == GAME_OVER));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      if (point_strobe && ovr_touch) saw_both = 1'b1;
      if (ovr_touch) saw_ovr = 1'b1;
   endtask

   task automatic idle(input int k);
      repeat (k) cyc();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic wait_play(input string tag);
      bit ok;
      ok = (state == PLAY);
      for (int i = 0; i < 80 && !ok; i++) begin
         cyc();
         if (state == PLAY) ok = 1'b1;
      end
      chk(tag, 8'(ok), 8'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen, back, w4;
      int hold_len;

      // Reset state
      model_reset();
      #1;
      check_all();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // 1: ground point on player1 side, then a full hold
      idle(3);
      ball_posx = 12'($urandom_range(0, 400));
      gnd_col = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         cyc();
         if (point_strobe) seen = 1'b1;
      end
      chk("s1_point_seen", 8'(seen), 8'd1);
      chk("s1_pl2_score", 8'(pl2_score), 8'd1);
      chk("s1_last_touch", 8'(last_touch), 8'd1);
      gnd_col = 1'b0;
      hold_len = 0; back = 1'b0;
      for (int i = 0; i < 60 && !back; i++) begin
         cyc();
         if (state == HOLD) hold_len++;
         else if (state == PLAY) back = 1'b1;
      end
      chk("s1_back_to_play", 8'(back), 8'd1);
      chk("s1_hold_cycles", 8'(hold_len), 8'd16);

      // 2: four player1 touches -> fault
      saw_both = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pl1_col = 1'b1; cyc();
         pl1_col = 1'b0; idle(9);
      end
      chk("s2_ovr_with_strobe", 8'(saw_both), 8'd1);
      chk("s2_pl2_score", 8'(pl2_score), 8'd2);
      chk("s2_last_touch", 8'(last_touch), 8'd1);
      wait_play("s2_wait_play");

      // 3: ghosted second touch, then possession change
      pl1_col = 1'b1; cyc(); pl1_col = 1'b0; idle(2);
      pl1_col = 1'b1; cyc(); pl1_col = 1'b0; idle(4);
      chk("s3_ghost_cnt", 8'(touch_cnt), 8'd1);
      chk("s3_ghost_last", 8'(last_touch), 8'd0);
      pl2_col = 1'b1; cyc(); pl2_col = 1'b0; idle(3);
      chk("s3_p2_last", 8'(last_touch), 8'd1);
      chk("s3_p2_cnt", 8'(touch_cnt), 8'd1);

      // 4: simultaneous touches, then ground beats a 4th touch
      idle(10);
      pl1_col = 1'b1; cyc(); pl1_col = 1'b0; idle(3);
      chk("s4_p1_last", 8'(last_touch), 8'd0);
      idle(6);
      pl1_col = 1'b1; pl2_col = 1'b1; cyc();
      pl1_col = 1'b0; pl2_col = 1'b0; idle(3);
      chk("s4_both_last", 8'(last_touch), 8'd1);
      chk("s4_both_cnt", 8'(touch_cnt), 8'd1);
      for (int k = 0; k < 2; k++) begin
         idle(6); pl2_col = 1'b1; cyc(); pl2_col = 1'b0; idle(3);
      end
      chk("s4_cnt3", 8'(touch_cnt), 8'd3);
      idle(6);
      ball_posx = 12'($urandom_range(0, 959));
      w4 = (int'(ball_posx) + 32 < 512);
      saw_ovr = 1'b0;
      pl2_col = 1'b1; gnd_col = 1'b1; cyc();
      pl2_col = 1'b0; idle(4);
      gnd_col = 1'b0;
      chk("s4_no_ovr", 8'(saw_ovr), 8'd0);
      chk("s4_pl1_score", 8'(pl1_score), w4 ? 8'd0 : 8'd1);
      chk("s4_pl2_score", 8'(pl2_score), w4 ? 8'd3 : 8'd2);
      idle(2);

      // 5: player1 wins three ground points, game over, new game
      apply_reset();
      idle(2);
      for (int k = 0; k < 3; k++) begin
         ball_posx = 12'($urandom_range(480, 959));
         gnd_col = 1'b1; idle(2); gnd_col = 1'b0;
         if (k < 2) wait_play("s5_wait_play");
         else idle(4);
      end
      chk("s5_game_over", 8'(game_over), 8'd1);
      chk("s5_pl1_score", 8'(pl1_score), 8'd3);
      ball_posx = 12'd100;
      gnd_col = 1'b1; pl1_col = 1'b1; pl2_col = 1'b1; idle(10);
      gnd_col = 1'b0; pl1_col = 1'b0; pl2_col = 1'b0; idle(3);
      chk("s5_frozen_pl1", 8'(pl1_score), 8'd3);
      chk("s5_frozen_pl2", 8'(pl2_score), 8'd0);
      chk("s5_still_over", 8'(game_over), 8'd1);
      new_game = 1'b1; cyc(); new_game = 1'b0; cyc();
      chk("s5_new_pl1", 8'(pl1_score), 8'd0);
      chk("s5_new_last", 8'(last_touch), 8'd0);
      chk("s5_new_state", 8'(state), 8'(PLAY));

      // 6: reset during hold with the ball on the ground
      idle(2);
      ball_posx = 12'd100; gnd_col = 1'b1; idle(6);
      chk("s6_in_hold", 8'(state), 8'(HOLD));
      apply_reset();
      chk("s6_rst_pl2", 8'(pl2_score), 8'd0);
      idle(10);
      chk("s6_state_play", 8'(state), 8'(PLAY));
      chk("s6_no_score", 8'(pl1_score + pl2_score), 8'd0);
      gnd_col = 1'b0;

      // Random phase
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) pl1_col = ~pl1_col;
         if ($urandom_range(0, 3) == 0) pl2_col = ~pl2_col;
         if ($urandom_range(0, 9) == 0) gnd_col = ~gnd_col;
         ball_posx = 12'($urandom_range(0, 959));
         new_game = ($urandom_range(0, 29) == 0);
         cyc();
      end
      new_game = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
